// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator with valid/ready
// handshaking and a pass-through tag. Results leave in acceptance order.
// Optional feature macro: IMM_GEN_CSR_EN (decode CSR-immediate forms as Z).
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic [2:0]       imm_type,
   output logic             illegal,
   output logic [TAG_W-1:0] tag_out
);

   localparam logic [2:0] TYPE_NONE = 3'd0;
   localparam logic [2:0] TYPE_I    = 3'd1;
   localparam logic [2:0] TYPE_S    = 3'd2;
   localparam logic [2:0] TYPE_B    = 3'd3;
   localparam logic [2:0] TYPE_U    = 3'd4;
   localparam logic [2:0] TYPE_J    = 3'd5;
`ifdef IMM_GEN_CSR_EN
   localparam logic [2:0] TYPE_Z    = 3'd6;
`endif

   logic [31:0]      dec_imm32;
   logic [2:0]       dec_type;
   logic             dec_ill;
   logic             accept;
   logic             take [DEPTH];

   logic             valid_q [DEPTH];
   logic             valid_d [DEPTH];
   logic [XLEN-1:0]  imm_q   [DEPTH];
   logic [XLEN-1:0]  imm_d   [DEPTH];
   logic [2:0]       type_q  [DEPTH];
   logic [2:0]       type_d  [DEPTH];
   logic             ill_q   [DEPTH];
   logic             ill_d   [DEPTH];
   logic [TAG_W-1:0] tag_q   [DEPTH];
   logic [TAG_W-1:0] tag_d   [DEPTH];

   // Decode the immediate of the incoming instruction as a 32-bit value;
   // the Z form has bit 31 clear, so one sign extension serves every format.
   always_comb begin
      dec_imm32 = '0;
      dec_type  = TYPE_NONE;
      dec_ill   = 1'b0;
      case (inst_in[6:0])
         7'b1100111, 7'b0000011, 7'b0010011: begin
            dec_type  = TYPE_I;
            dec_imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
         end
         7'b0100011: begin
            dec_type  = TYPE_S;
            dec_imm32 = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
         end
         7'b1100011: begin
            dec_type  = TYPE_B;
            dec_imm32 = {{20{inst_in[31]}}, inst_in[7], inst_in[30:25],
                         inst_in[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_type  = TYPE_U;
            dec_imm32 = {inst_in[31:12], 12'b0};
         end
         7'b1101111: begin
            dec_type  = TYPE_J;
            dec_imm32 = {{12{inst_in[31]}}, inst_in[19:12], inst_in[20],
                         inst_in[30:21], 1'b0};
         end
         7'b0110011, 7'b0001111: begin
            dec_type = TYPE_NONE;
         end
         7'b1110011: begin
`ifdef IMM_GEN_CSR_EN
            if (inst_in[14]) begin
               dec_type  = TYPE_Z;
               dec_imm32 = {27'b0, inst_in[19:15]};
            end
`else
            dec_type = TYPE_NONE;
`endif
         end
         default: begin
            dec_ill = 1'b1;
         end
      endcase
   end

   // A stage can take new contents when it, or any stage downstream of it,
   // is empty, or when the consumer drains the last stage (bubbles collapse).
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         take[k] = out_ready;
         for (int j = k; j < DEPTH; j++) begin
            if (!valid_q[j]) take[k] = 1'b1;
         end
      end
   end

   assign in_ready = !rst && !flush && take[0];
   assign accept   = in_valid && in_ready;

   // Next-state for every stage: load from upstream when allowed, else hold.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         valid_d[k] = valid_q[k];
         imm_d[k]   = imm_q[k];
         type_d[k]  = type_q[k];
         ill_d[k]   = ill_q[k];
         tag_d[k]   = tag_q[k];
      end
      if (take[0]) begin
         valid_d[0] = accept;
         imm_d[0]   = XLEN'($signed(dec_imm32));
         type_d[0]  = dec_type;
         ill_d[0]   = dec_ill;
         tag_d[0]   = tag_in;
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (take[k]) begin
            valid_d[k] = valid_q[k-1];
            imm_d[k]   = imm_q[k-1];
            type_d[k]  = type_q[k-1];
            ill_d[k]   = ill_q[k-1];
            tag_d[k]   = tag_q[k-1];
         end
      end
      if (flush) begin
         for (int k = 0; k < DEPTH; k++) valid_d[k] = 1'b0;
      end
   end

   // Stage registers; reset clears valid bits and data alike.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_q[k] <= 1'b0;
            imm_q[k]   <= '0;
            type_q[k]  <= TYPE_NONE;
            ill_q[k]   <= 1'b0;
            tag_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_q[k] <= valid_d[k];
            imm_q[k]   <= imm_d[k];
            type_q[k]  <= type_d[k];
            ill_q[k]   <= ill_d[k];
            tag_q[k]   <= tag_d[k];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign imm_out   = imm_q[DEPTH-1];
   assign imm_type  = type_q[DEPTH-1];
   assign illegal   = ill_q[DEPTH-1];
   assign tag_out   = tag_q[DEPTH-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: instance A (XLEN=32, DEPTH=2) and instance B
// (XLEN=64, DEPTH=3) share stimulus; 'sel' routes handshakes to one of them.
module tb_imm_gen_pipe;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  t;
      logic        il;
      logic [7:0]  tag;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready, sel;
   logic [31:0] inst_in;
   logic [7:0]  tag_in;

   logic        in_ready_a, out_valid_a, illegal_a;
   logic [31:0] imm_a;
   logic [2:0]  type_a;
   logic [7:0]  tag_a;
   logic        in_ready_b, out_valid_b, illegal_b;
   logic [63:0] imm_b;
   logic [2:0]  type_b;
   logic [7:0]  tag_b;

   logic        in_ready, out_valid, illegal;
   logic [63:0] imm_out;
   logic [2:0]  imm_type;
   logic [7:0]  tag_out;

   sb_t         sb[$];
   sb_t         pending;
   sb_t         popped;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(8)) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid && !sel), .in_ready(in_ready_a),
      .inst_in(inst_in), .tag_in(tag_in),
      .out_valid(out_valid_a), .out_ready(out_ready && !sel),
      .imm_out(imm_a), .imm_type(type_a), .illegal(illegal_a), .tag_out(tag_a));

   imm_gen_pipe #(.XLEN(64), .DEPTH(3), .TAG_W(8)) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid && sel), .in_ready(in_ready_b),
      .inst_in(inst_in), .tag_in(tag_in),
      .out_valid(out_valid_b), .out_ready(out_ready && sel),
      .imm_out(imm_b), .imm_type(type_b), .illegal(illegal_b), .tag_out(tag_b));

   assign in_ready  = sel ? in_ready_b  : in_ready_a;
   assign out_valid = sel ? out_valid_b : out_valid_a;
   assign imm_out   = sel ? imm_b       : {32'b0, imm_a};
   assign imm_type  = sel ? type_b      : type_a;
   assign illegal   = sel ? illegal_b   : illegal_a;
   assign tag_out   = sel ? tag_b       : tag_a;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference decode, written from the instruction-set field layouts.
   function automatic sb_t model(input logic [31:0] i, input logic x64,
                                 input logic [7:0] tg);
      sb_t         r;
      logic [31:0] v;
      v     = 32'h0;
      r.t   = 3'd0;
      r.il  = 1'b0;
      r.tag = tg;
      case (i[6:0])
         7'h67, 7'h03, 7'h13: begin r.t = 3'd1; v = {{20{i[31]}}, i[31:20]}; end
         7'h23: begin r.t = 3'd2; v = {{20{i[31]}}, i[31:25], i[11:7]}; end
         7'h63: begin r.t = 3'd3; v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
         7'h37, 7'h17: begin r.t = 3'd4; v = {i[31:12], 12'h000}; end
         7'h6F: begin r.t = 3'd5; v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
         7'h33, 7'h0F: ;
         7'h73: begin
`ifdef IMM_GEN_CSR_EN
            if (i[14]) begin r.t = 3'd6; v = {27'b0, i[19:15]}; end
`endif
         end
         default: r.il = 1'b1;
      endcase
      r.imm = x64 ? {{32{v[31]}}, v} : {32'h0, v};
      return r;
   endfunction

   // Scoreboard: pop on output handshake, push on input handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_out", 64'(tag_out), 64'hDEAD);
            end else begin
               popped = sb.pop_front();
               check("imm_out",  imm_out,            popped.imm);
               check("imm_type", 64'(imm_type),      64'(popped.t));
               check("illegal",  64'(illegal),       64'(popped.il));
               check("tag_out",  64'(tag_out),       64'(popped.tag));
            end
         end
         if (in_valid && in_ready) sb.push_back(pending);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_raw(input logic [31:0] inst, input sb_t e, output int waits);
      logic acc;
      pending  = e;
      inst_in  = inst;
      tag_in   = e.tag;
      in_valid = 1'b1;
      waits    = 0;
      forever begin
         @(negedge clk);
         acc = in_ready;
         cyc();
         if (acc) break;
         waits++;
         if (waits > 60) begin
            check("push_timeout", 64'(waits), 64'd0);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] inst, input logic [7:0] tg,
                           input logic [63:0] imm, input logic [2:0] t,
                           input logic il);
      sb_t e;
      int  w;
      e.imm = imm; e.t = t; e.il = il; e.tag = tg;
      push_raw(inst, e, w);
   endtask

   task automatic push_mod(input logic [31:0] inst, input logic [7:0] tg,
                           output int waits);
      push_raw(inst, model(inst, sel, tg), waits);
   endtask

   task automatic lat_check(input int depth);
      for (int i = 0; i < depth - 1; i++) begin
         @(negedge clk);
         check("latency_early", 64'(out_valid), 64'd0);
      end
      @(negedge clk);
      check("latency_due", 64'(out_valid), 64'd1);
      cyc();
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 100) begin
         cyc();
         n++;
      end
      check("drain_left", 64'(sb.size()), 64'd0);
      @(negedge clk);
      check("idle_out_valid", 64'(out_valid), 64'd0);
      cyc();
   endtask

   logic [6:0]  ops [12];
   logic [31:0] r;
   int          w;

   initial begin
      ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
              7'h17, 7'h6F, 7'h33, 7'h73, 7'h7F, 7'h0B};
      sel = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1; inst_in = 32'h0; tag_in = 8'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_imm",       imm_out,        64'd0);
      check("rst_type",      64'(imm_type),  64'd0);
      check("rst_illegal",   64'(illegal),   64'd0);
      check("rst_tag",       64'(tag_out),   64'd0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      cyc();

      // Instance A: I-format latency, then directed vectors
      push_exp(32'h80100013, 8'h11, 64'h00000000FFFFF801, 3'd1, 1'b0);
      lat_check(2);
      push_exp(32'hFFE5506F, 8'h21, 64'h00000000FFF557FE, 3'd5, 1'b0);
      push_exp(32'h00001037, 8'h22, 64'h0000000000001000, 3'd4, 1'b0);
      push_exp(32'h0000007F, 8'h23, 64'h0, 3'd0, 1'b1);
`ifdef IMM_GEN_CSR_EN
      push_exp(32'h000FD073, 8'h24, 64'h1F, 3'd6, 1'b0);
`else
      push_exp(32'h000FD073, 8'h24, 64'h0, 3'd0, 1'b0);
`endif
      drain();

      // Back-to-back streaming: every push accepted first cycle
      for (int i = 0; i < 10; i++) begin
         r = $urandom();
         push_mod({r[31:7], ops[$urandom_range(0, 11)]}, 8'(i + 8'h40), w);
         check("stream_accept", 64'(w), 64'd0);
      end
      drain();

      // Backpressure on A (DEPTH=2)
      out_ready = 1'b0;
      push_exp(32'h00500093, 8'hA0, 64'h5, 3'd1, 1'b0);
      push_exp(32'h00A00113, 8'hB0, 64'hA, 3'd1, 1'b0);
      pending  = model(32'hFFF00193, 1'b0, 8'hC0);
      inst_in  = 32'hFFF00193;
      tag_in   = 8'hC0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready),  64'd0);
         check("bp_hold_tag", 64'(tag_out),   64'hA0);
         check("bp_hold_imm", imm_out,        64'h5);
         cyc();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_first_tag",        64'(tag_out),  64'hA0);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_second_valid", 64'(out_valid), 64'd1);
      check("bp_second_tag",   64'(tag_out),   64'hB0);
      cyc();
      @(negedge clk);
      check("bp_third_valid", 64'(out_valid), 64'd1);
      check("bp_third_tag",   64'(tag_out),   64'hC0);
      cyc();
      drain();

      // Instance B (XLEN=64, DEPTH=3): sign extension of U-format
      sel = 1'b1;
      push_exp(32'h80000037, 8'h31, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      lat_check(3);
      for (int i = 0; i < 6; i++) begin
         r = $urandom();
         push_mod({r[31:7], ops[$urandom_range(0, 11)]}, 8'(i + 8'h60), w);
      end
      drain();

      // Flush with three in flight
      out_ready = 1'b0;
      push_mod(32'h12345013, 8'hE1, w);
      push_mod(32'h23456013, 8'hE2, w);
      push_mod(32'h34567013, 8'hE3, w);
      out_ready = 1'b1;
      flush     = 1'b1;
      pending   = model(32'h45678013, 1'b1, 8'hEE);
      inst_in   = 32'h45678013;
      tag_in    = 8'hEE;
      in_valid  = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'd0);
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      cyc();
      push_mod(32'hABCDE017, 8'h5A, w);
      lat_check(3);
      drain();

      // Reset mid-stream on A
      sel       = 1'b0;
      out_ready = 1'b0;
      push_mod(32'hFFF00013, 8'h77, w);
      push_mod(32'h8000006F, 8'h78, w);
      rst      = 1'b1;
      inst_in  = 32'h00100013;
      in_valid = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      cyc();
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_imm",       imm_out,        64'd0);
      check("midrst_type",      64'(imm_type),  64'd0);
      check("midrst_illegal",   64'(illegal),   64'd0);
      check("midrst_tag",       64'(tag_out),   64'd0);
      check("midrst_in_ready2", 64'(in_ready),  64'd0);
      cyc();
      rst      = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      check("release_in_ready", 64'(in_ready), 64'd1);
      cyc();
      out_ready = 1'b1;
      push_mod(32'h0040A023, 8'h99, w);
      lat_check(2);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator with valid/ready handshaking, the successor to the combinational IMM_GEN. It decodes the immediate of every RV32I/RV64I base format and sign-extends it to XLEN. It also reports the immediate format and flags unknown opcodes. It sits between the fetch queue and the decode/issue stage and carries an opaque tag (e.g. PC index) alongside each instruction.

## Interface
- XLEN, 32, immediate output width; legal values 32 and 64.
- DEPTH, 2, number of registered pipeline stages; legal values 1–4.
- TAG_W, 8, width of the pass-through tag.
- clk  input  1  rising-edge clock.
- rst  input  1  reset: synchronous, active-high.
- flush  input  1  synchronous pipeline clear.
- in_valid  input  1  instruction present.
- in_ready  output  1  block accepts this cycle.
- inst_in  input  32  instruction word.
- tag_in  input  TAG_W  pass-through tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- imm_out  output  XLEN  sign/zero-extended immediate.
- imm_type  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- illegal  output  1  opcode not recognised.
- tag_out  output  TAG_W  tag of the result.

## Operation
- Immediate is computed combinationally on inst_in and captured into stage 0 on accept (in_valid && in_ready). It then advances one stage per cycle.
- Decode by inst[6:0]:
  - 1100111, 0000011, 0010011 → I; imm = sext(inst[31:20]).
  - 0100011 → S; imm = sext({inst[31:25], inst[11:7]}).
  - 1100011 → B; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 0110111, 0010111 → U; imm = sext({inst[31:12], 12'b0}). Bit 31 extends to XLEN when XLEN=64.
  - 1101111 → J; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - 0110011, 0001111, 1110011 (except Z case below) → NONE; imm = 0; illegal = 0.
  - Any other opcode → NONE; imm = 0; illegal = 1.
- Each stage holds {valid, imm, type, illegal, tag}.
- Stage k loads from stage k-1 when stage k is empty or is itself advancing. Bubbles collapse.
- Last stage drives the outputs.
- Stage-advance rule: last stage advances when out_ready. Stage k advances when stage k+1 is empty or advancing.
- in_ready = !rst && !flush && (stage 0 empty or stage 0 advancing).
- Tags and results emerge strictly in acceptance order; none are dropped or duplicated except by flush/rst.

## Timing
- Reset values: all stage valid bits 0, so out_valid = 0. imm_out = 0, imm_type = 0, illegal = 0, tag_out = 0. in_ready = 0 while rst is high.
- Latency: an instruction accepted at edge N appears with out_valid = 1 after edge N+DEPTH-1, i.e. DEPTH cycles from presentation.
- Throughput: one per cycle with out_ready held high.
- in_ready depends combinationally on out_ready through the stage chain. It has no combinational dependency on in_valid.
- Output stability: while out_valid && !out_ready, imm_out, imm_type, illegal and tag_out are held stable.
- Full pipeline (all DEPTH stages valid) with out_ready = 0 → in_ready = 0.
- Full pipeline with out_ready = 1 → in_ready = 1; push and pop occur on the same edge.
- flush: at the edge, all valid bits clear. in_ready = 0 during the flush cycle, so no instruction is accepted. out_valid = 0 the next cycle.
- rst mid-stream behaves the same as flush; data registers also return to 0.
- rst has priority over flush.

## Configuration
- IMM_GEN_CSR_EN defined: opcode 1110011 with inst[14] = 1 (csrrwi/csrrsi/csrrci) → Z; imm = zero-extended inst[19:15]; illegal = 0.
- IMM_GEN_CSR_EN undefined: those encodings → NONE; imm = 0; illegal = 0. Type code 6 is never produced.

## Test plan
- XLEN=32, DEPTH=2: push 0x80100013 (tag 0x11) → two cycles later out_valid = 1, imm_out = 0xFFFFF801, imm_type = 1, tag_out = 0x11.
- J-format: push 0xFFE5506F → imm_out = 0xFFF557FE, imm_type = 5. Push 0x00001037 → 0x00001000, type 4.
- XLEN=64: push 0x80000037 → imm_out = 0xFFFFFFFF80000000, type 4.
- Opcode 0x7F: push 0x0000007F → type 0, imm 0, illegal = 1.
- Back-to-back streaming with out_ready high → one result per cycle, in order.
- CSR immediate: push 0x000FD073.
  - With IMM_GEN_CSR_EN → imm = 0x1F, type 6.
  - Without → imm = 0, type 0, illegal = 0.
- Backpressure, DEPTH=2, out_ready = 0: push A, B, C.
  - A and B are accepted; in_ready = 0 with C held.
  - Raise out_ready → A, B, C emerge on consecutive cycles. C is accepted the cycle out_ready rises.
- Flush: DEPTH=3, three instructions in flight; assert flush one cycle → out_valid = 0 the next cycle, no stale tag appears. A push after the flush emerges after 3 cycles.
- Reset: assert rst mid-stream → every output is 0 the cycle after. in_ready = 0 while rst is high and 1 after release.
